// File: rtl/axilite_master.sv
// axilite_master: initiator side of the fsic AXI-Lite link.
// Converts single-cycle backend start pulses into AXI-Lite write (AW then W)
// and read (AR then R) transactions. Write and read paths are independent
// FSMs, each with one outstanding transaction. All outputs are registered.
// Optional feature macro: AXI_BRESP_EN adds the B channel (axi_bvalid,
// axi_bresp, axi_bready) plus req_werr; without it writes are posted and
// req_wdone follows the W handshake.
module axilite_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  req_wstart,
  input  logic [ADDR_W-1:0]     req_waddr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  req_wbusy,
  output logic                  req_wdone,
  input  logic                  req_rstart,
  input  logic [ADDR_W-1:0]     req_raddr,
  output logic                  req_rbusy,
  output logic                  req_rdone,
  output logic [DATA_W-1:0]     req_rdata,
  output logic                  axi_awvalid,
  output logic [ADDR_W-1:0]     axi_awaddr,
  input  logic                  axi_awready,
  output logic                  axi_wvalid,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  input  logic                  axi_wready,
`ifdef AXI_BRESP_EN
  input  logic                  axi_bvalid,
  input  logic [1:0]            axi_bresp,
  output logic                  axi_bready,
  output logic                  req_werr,
`endif
  output logic                  axi_arvalid,
  output logic [ADDR_W-1:0]     axi_araddr,
  input  logic                  axi_arready,
  input  logic                  axi_rvalid,
  input  logic [DATA_W-1:0]     axi_rdata,
  output logic                  axi_rready
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  wstate_t               wstate_q, wstate_d;
  logic                  awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  wbusy_q, wbusy_d;
  logic                  wdone_q, wdone_d;
`ifdef AXI_BRESP_EN
  logic                  bready_q, bready_d;
  logic                  werr_q, werr_d;
`endif

  rstate_t               rstate_q, rstate_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]     araddr_q, araddr_d;
  logic                  rready_q, rready_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rbusy_q, rbusy_d;
  logic                  rdone_q, rdone_d;

  // Write path next-state: AW beat first, W beat only after AW is accepted.
  always_comb begin
    wstate_d  = wstate_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    wvalid_d  = wvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wbusy_d   = wbusy_q;
    wdone_d   = 1'b0;
`ifdef AXI_BRESP_EN
    bready_d  = bready_q;
    werr_d    = werr_q;
`endif
    case (wstate_q)
      W_IDLE: begin
        if (req_wstart) begin
          // Request fields are captured only here, so starts while busy are ignored.
          wstate_d  = W_ADDR;
          awvalid_d = 1'b1;
          awaddr_d  = req_waddr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          wbusy_d   = 1'b1;
        end else begin
          wstate_d  = W_IDLE;
        end
      end
      W_ADDR: begin
        if (awvalid_q && axi_awready) begin
          wstate_d  = W_DATA;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
        end else begin
          wstate_d  = W_ADDR;
        end
      end
      W_DATA: begin
        if (wvalid_q && axi_wready) begin
          wvalid_d = 1'b0;
`ifdef AXI_BRESP_EN
          wstate_d = W_RESP;
          bready_d = 1'b1;
`else
          wstate_d = W_IDLE;
          wbusy_d  = 1'b0;
          wdone_d  = 1'b1;
`endif
        end else begin
          wstate_d = W_DATA;
        end
      end
`ifdef AXI_BRESP_EN
      W_RESP: begin
        if (bready_q && axi_bvalid) begin
          wstate_d = W_IDLE;
          bready_d = 1'b0;
          wbusy_d  = 1'b0;
          wdone_d  = 1'b1;
          werr_d   = (axi_bresp != 2'b00);
        end else begin
          wstate_d = W_RESP;
        end
      end
`endif
      default: begin
        // Unreachable encoding: fall back to a quiet idle path.
        wstate_d  = W_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        wbusy_d   = 1'b0;
`ifdef AXI_BRESP_EN
        bready_d  = 1'b0;
`endif
      end
    endcase
  end

  // Write path state and output registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wstate_q  <= W_IDLE;
      awvalid_q <= 1'b0;
      awaddr_q  <= {ADDR_W{1'b0}};
      wvalid_q  <= 1'b0;
      wdata_q   <= {DATA_W{1'b0}};
      wstrb_q   <= {(DATA_W/8){1'b0}};
      wbusy_q   <= 1'b0;
      wdone_q   <= 1'b0;
`ifdef AXI_BRESP_EN
      bready_q  <= 1'b0;
      werr_q    <= 1'b0;
`endif
    end else begin
      wstate_q  <= wstate_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      wvalid_q  <= wvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wbusy_q   <= wbusy_d;
      wdone_q   <= wdone_d;
`ifdef AXI_BRESP_EN
      bready_q  <= bready_d;
      werr_q    <= werr_d;
`endif
    end
  end

  // Read path next-state: AR beat, then hold rready until the R beat arrives.
  always_comb begin
    rstate_d  = rstate_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    rbusy_d   = rbusy_q;
    rdone_d   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (req_rstart) begin
          rstate_d  = R_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = req_raddr;
          rbusy_d   = 1'b1;
        end else begin
          rstate_d  = R_IDLE;
        end
      end
      R_ADDR: begin
        if (arvalid_q && axi_arready) begin
          rstate_d  = R_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else begin
          rstate_d  = R_ADDR;
        end
      end
      R_DATA: begin
        if (rready_q && axi_rvalid) begin
          rstate_d = R_IDLE;
          rready_d = 1'b0;
          rdata_d  = axi_rdata;
          rbusy_d  = 1'b0;
          rdone_d  = 1'b1;
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: begin
        rstate_d  = R_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        rbusy_d   = 1'b0;
      end
    endcase
  end

  // Read path state and output registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rstate_q  <= R_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= {ADDR_W{1'b0}};
      rready_q  <= 1'b0;
      rdata_q   <= {DATA_W{1'b0}};
      rbusy_q   <= 1'b0;
      rdone_q   <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      rbusy_q   <= rbusy_d;
      rdone_q   <= rdone_d;
    end
  end

  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign req_wbusy   = wbusy_q;
  assign req_wdone   = wdone_q;
`ifdef AXI_BRESP_EN
  assign axi_bready  = bready_q;
  assign req_werr    = werr_q;
`endif
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_rready  = rready_q;
  assign req_rdata   = rdata_q;
  assign req_rbusy   = rbusy_q;
  assign req_rdone   = rdone_q;

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master: a small slave model with per-test
// ready/valid delays, a per-cycle bus monitor (stability, AW/W overlap,
// handshake capture) and directed transactions with hand-computed values.
`define CK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_axilite_master;
  logic        axi_aclk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        req_wstart = 1'b0;
  logic [11:0] req_waddr = 12'h000;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        req_wbusy, req_wdone;
  logic        req_rstart = 1'b0;
  logic [11:0] req_raddr = 12'h000;
  logic        req_rbusy, req_rdone;
  logic [31:0] req_rdata;
  logic        axi_awvalid, axi_wvalid, axi_arvalid, axi_rready;
  logic [11:0] axi_awaddr, axi_araddr;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_awready = 1'b0, axi_wready = 1'b0, axi_arready = 1'b0, axi_rvalid = 1'b0;
  logic [31:0] axi_rdata = 32'h0;
`ifdef AXI_BRESP_EN
  logic        axi_bvalid = 1'b0;
  logic [1:0]  axi_bresp = 2'b00;
  logic        axi_bready, req_werr;
`endif

  int tests = 0, fails = 0;
  int aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0, b_dly = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, b_wait = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, r_hs = 0, wdone_cnt = 0, rdone_cnt = 0;
  int awh0, wh0, arh0, rh0, wd0, rd0;
  logic [31:0] r_val = 32'h0;
  logic [1:0]  b_resp = 2'b00;
  logic [11:0] cap_awaddr = 12'h0, cap_araddr = 12'h0, p_awaddr = 12'h0, p_araddr = 12'h0;
  logic [31:0] cap_wdata = 32'h0, p_wdata = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0, p_wstrb = 4'h0;
  logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
  logic        p_arv = 1'b0, p_arr = 1'b0, p_rrdy = 1'b0, p_rv = 1'b0;
  logic        seen, seen_w, seen_r;
  logic [11:0] e_waddr, e_raddr;
  logic [31:0] e_wdata, e_rdata;

  axilite_master #(.ADDR_W(12), .DATA_W(32)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .req_wstart(req_wstart), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .req_wbusy(req_wbusy), .req_wdone(req_wdone),
    .req_rstart(req_rstart), .req_raddr(req_raddr), .req_rbusy(req_rbusy),
    .req_rdone(req_rdone), .req_rdata(req_rdata),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wready(axi_wready),
`ifdef AXI_BRESP_EN
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .req_werr(req_werr),
`endif
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rready(axi_rready)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor plus slave model, evaluated at each falling edge.
  task automatic monitor();
    if (axi_aresetn) begin
      if (p_awv && !p_awr) begin
        `CK("aw_valid_hold", axi_awvalid, 1'b1);
        `CK("aw_addr_hold", axi_awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        `CK("w_valid_hold", axi_wvalid, 1'b1);
        `CK("w_data_hold", axi_wdata, p_wdata);
        `CK("w_strb_hold", axi_wstrb, p_wstrb);
      end
      if (p_arv && !p_arr) begin
        `CK("ar_valid_hold", axi_arvalid, 1'b1);
        `CK("ar_addr_hold", axi_araddr, p_araddr);
      end
      if (p_rrdy && !p_rv) `CK("rready_hold", axi_rready, 1'b1);
      `CK("aw_w_overlap", axi_awvalid & axi_wvalid, 1'b0);
      if (req_wdone) wdone_cnt++;
      if (req_rdone) rdone_cnt++;
      if (axi_awvalid) begin axi_awready = (aw_wait >= aw_dly); aw_wait++; end
      else begin axi_awready = 1'b0; aw_wait = 0; end
      if (axi_wvalid) begin axi_wready = (w_wait >= w_dly); w_wait++; end
      else begin axi_wready = 1'b0; w_wait = 0; end
      if (axi_arvalid) begin axi_arready = (ar_wait >= ar_dly); ar_wait++; end
      else begin axi_arready = 1'b0; ar_wait = 0; end
      axi_rdata = r_val;
      if (axi_rready) begin axi_rvalid = (r_wait >= r_dly); r_wait++; end
      else begin axi_rvalid = 1'b0; r_wait = 0; end
`ifdef AXI_BRESP_EN
      axi_bresp = b_resp;
      if (axi_bready) begin axi_bvalid = (b_wait >= b_dly); b_wait++; end
      else begin axi_bvalid = 1'b0; b_wait = 0; end
`endif
      if (axi_awvalid && axi_awready) begin aw_hs++; cap_awaddr = axi_awaddr; end
      if (axi_wvalid && axi_wready) begin w_hs++; cap_wdata = axi_wdata; cap_wstrb = axi_wstrb; end
      if (axi_arvalid && axi_arready) begin ar_hs++; cap_araddr = axi_araddr; end
      if (axi_rvalid && axi_rready) r_hs++;
      p_awv = axi_awvalid; p_awr = axi_awready; p_awaddr = axi_awaddr;
      p_wv = axi_wvalid; p_wr = axi_wready; p_wdata = axi_wdata; p_wstrb = axi_wstrb;
      p_arv = axi_arvalid; p_arr = axi_arready; p_araddr = axi_araddr;
      p_rrdy = axi_rready; p_rv = axi_rvalid;
    end else begin
      axi_awready = 1'b0; axi_wready = 1'b0; axi_arready = 1'b0; axi_rvalid = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0; b_wait = 0;
`ifdef AXI_BRESP_EN
      axi_bvalid = 1'b0;
`endif
      p_awv = 1'b0; p_awr = 1'b0; p_wv = 1'b0; p_wr = 1'b0;
      p_arv = 1'b0; p_arr = 1'b0; p_rrdy = 1'b0; p_rv = 1'b0;
    end
  endtask

  // One clock: monitor at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge axi_aclk);
    monitor();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic wait_wdone(input string tag, input int budget);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (req_wdone) seen = 1'b1;
      else `CK({tag, "_wbusy_held"}, req_wbusy, 1'b1);
    end
    `CK({tag, "_wdone_seen"}, seen, 1'b1);
  endtask

  task automatic wait_rdone(input string tag, input int budget);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (req_rdone) seen = 1'b1;
      else `CK({tag, "_rbusy_held"}, req_rbusy, 1'b1);
    end
    `CK({tag, "_rdone_seen"}, seen, 1'b1);
  endtask

  task automatic chk_zero(input string tag);
    `CK({tag, "_awvalid"}, axi_awvalid, 1'b0);
    `CK({tag, "_wvalid"}, axi_wvalid, 1'b0);
    `CK({tag, "_arvalid"}, axi_arvalid, 1'b0);
    `CK({tag, "_rready"}, axi_rready, 1'b0);
    `CK({tag, "_wbusy"}, req_wbusy, 1'b0);
    `CK({tag, "_rbusy"}, req_rbusy, 1'b0);
    `CK({tag, "_wdone"}, req_wdone, 1'b0);
    `CK({tag, "_rdone"}, req_rdone, 1'b0);
    `CK({tag, "_awaddr"}, axi_awaddr, 12'h000);
    `CK({tag, "_wdata"}, axi_wdata, 32'h0);
    `CK({tag, "_wstrb"}, axi_wstrb, 4'h0);
    `CK({tag, "_araddr"}, axi_araddr, 12'h000);
    `CK({tag, "_rdata"}, req_rdata, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge axi_aclk);
    #1;
    chk_zero("reset");
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk);
    #1;

    // Write 0x0A4 / 0x1234_5678 / 0xF, ready one cycle after valid
    aw_dly = 1; w_dly = 1;
    awh0 = aw_hs; wh0 = w_hs; wd0 = wdone_cnt;
    req_wstart = 1'b1; req_waddr = 12'h0A4; req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
    tick();
    req_wstart = 1'b0;
    `CK("w1_wbusy", req_wbusy, 1'b1);
    `CK("w1_awvalid", axi_awvalid, 1'b1);
    `CK("w1_awaddr", axi_awaddr, 12'h0A4);
    `CK("w1_wvalid_early", axi_wvalid, 1'b0);
    wait_wdone("w1", 20);
    `CK("w1_wbusy_done", req_wbusy, 1'b0);
    `CK("w1_aw_beats", aw_hs - awh0, 1);
    `CK("w1_w_beats", w_hs - wh0, 1);
    `CK("w1_cap_awaddr", cap_awaddr, 12'h0A4);
    `CK("w1_cap_wdata", cap_wdata, 32'h1234_5678);
    `CK("w1_cap_wstrb", cap_wstrb, 4'hF);
    tests++;
    if (cap_wdata !== 32'h1234_5678) begin
      fails++;
      $error("FAIL w1_cap_wdata_direct: observed 0x%0h", cap_wdata);
    end

    // New start in the wdone cycle is accepted
    req_wstart = 1'b1; req_waddr = 12'h0B0; req_wdata = 32'h0000_BEEF; req_wstrb = 4'h1;
    tick();
    req_wstart = 1'b0;
    `CK("w2_wdone_pulse", req_wdone, 1'b0);
    `CK("w2_wbusy", req_wbusy, 1'b1);
    `CK("w2_awvalid", axi_awvalid, 1'b1);
    `CK("w2_awaddr", axi_awaddr, 12'h0B0);
    wait_wdone("w2", 20);
    `CK("w2_cap_wdata", cap_wdata, 32'h0000_BEEF);
    `CK("w2_cap_wstrb", cap_wstrb, 4'h1);
    tick();
    `CK("w2_wdone_cnt", wdone_cnt - wd0, 2);
    `CK("w2_aw_beats", aw_hs - awh0, 2);

    // Read 0x010, data 3 cycles after AR handshake
    ar_dly = 1; r_dly = 3; r_val = 32'hCAFE_F00D;
    arh0 = ar_hs; rh0 = r_hs; rd0 = rdone_cnt;
    req_rstart = 1'b1; req_raddr = 12'h010;
    tick();
    req_rstart = 1'b0;
    `CK("r1_rbusy", req_rbusy, 1'b1);
    `CK("r1_arvalid", axi_arvalid, 1'b1);
    `CK("r1_araddr", axi_araddr, 12'h010);
    `CK("r1_rready_early", axi_rready, 1'b0);
    wait_rdone("r1", 30);
    `CK("r1_rdata", req_rdata, 32'hCAFE_F00D);
    tests++;
    if (req_rdata !== 32'hCAFE_F00D) begin
      fails++;
      $error("FAIL r1_rdata_direct: observed 0x%0h", req_rdata);
    end
    `CK("r1_rbusy_done", req_rbusy, 1'b0);
    `CK("r1_rready_after", axi_rready, 1'b0);
    `CK("r1_cap_araddr", cap_araddr, 12'h010);
    r_val = 32'h0;
    tick();
    `CK("r1_rdone_pulse", req_rdone, 1'b0);
    `CK("r1_rdata_held", req_rdata, 32'hCAFE_F00D);
    `CK("r1_rdone_cnt", rdone_cnt - rd0, 1);
    `CK("r1_ar_beats", ar_hs - arh0, 1);
    `CK("r1_r_beats", r_hs - rh0, 1);

    // Start while busy is ignored
    aw_dly = 3; w_dly = 2;
    awh0 = aw_hs; wd0 = wdone_cnt;
    req_wstart = 1'b1; req_waddr = 12'h100; req_wdata = 32'hA5A5_0001; req_wstrb = 4'h3;
    tick();
    req_wstart = 1'b0;
    tick();
    req_wstart = 1'b1; req_waddr = 12'hFFF; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    tick();
    req_wstart = 1'b0;
    `CK("busy_awaddr", axi_awaddr, 12'h100);
    `CK("busy_wdata", axi_wdata, 32'hA5A5_0001);
    tests++;
    if (axi_awaddr !== 12'h100) begin
      fails++;
      $error("FAIL busy_awaddr_direct: observed 0x%0h", axi_awaddr);
    end
    wait_wdone("busy", 30);
    `CK("busy_cap_awaddr", cap_awaddr, 12'h100);
    `CK("busy_cap_wdata", cap_wdata, 32'hA5A5_0001);
    `CK("busy_cap_wstrb", cap_wstrb, 4'h3);
    repeat (4) tick();
    `CK("busy_aw_beats", aw_hs - awh0, 1);
    `CK("busy_wdone_cnt", wdone_cnt - wd0, 1);
    `CK("busy_wbusy_idle", req_wbusy, 1'b0);

    // Simultaneous write and read with random stalls
    for (int k = 0; k < 3; k++) begin
      aw_dly = int'($urandom_range(0, 5)); w_dly = int'($urandom_range(0, 5));
      ar_dly = int'($urandom_range(0, 5)); r_dly = int'($urandom_range(0, 5));
      e_waddr = 12'h200 + 12'(k * 4); e_wdata = 32'h1000_0000 + 32'(k);
      e_raddr = 12'h300 + 12'(k);     e_rdata = 32'h5A5A_0000 + 32'(k);
      r_val = e_rdata;
      wd0 = wdone_cnt; rd0 = rdone_cnt;
      req_wstart = 1'b1; req_waddr = e_waddr; req_wdata = e_wdata; req_wstrb = 4'hC;
      req_rstart = 1'b1; req_raddr = e_raddr;
      tick();
      req_wstart = 1'b0; req_rstart = 1'b0;
      `CK("cc_both_busy", {req_wbusy, req_rbusy}, 2'b11);
      seen_w = 1'b0; seen_r = 1'b0;
      for (int i = 0; i < 200 && !(seen_w && seen_r); i++) begin
        tick();
        if (req_wdone) seen_w = 1'b1;
        if (req_rdone) begin
          seen_r = 1'b1;
          `CK("cc_rdata", req_rdata, e_rdata);
        end
      end
      `CK("cc_wdone_seen", seen_w, 1'b1);
      `CK("cc_rdone_seen", seen_r, 1'b1);
      `CK("cc_cap_awaddr", cap_awaddr, e_waddr);
      `CK("cc_cap_wdata", cap_wdata, e_wdata);
      `CK("cc_cap_araddr", cap_araddr, e_raddr);
      tests++;
      if (req_rdata !== e_rdata) begin
        fails++;
        $error("FAIL cc_rdata_direct: observed 0x%0h expected 0x%0h", req_rdata, e_rdata);
      end
      tests++;
      if (cap_wdata !== e_wdata) begin
        fails++;
        $error("FAIL cc_wdata_direct: observed 0x%0h expected 0x%0h", cap_wdata, e_wdata);
      end
      tick();
      `CK("cc_wdone_cnt", wdone_cnt - wd0, 1);
      `CK("cc_rdone_cnt", rdone_cnt - rd0, 1);
    end

    // Asynchronous reset while awvalid is high
    aw_dly = 20;
    awh0 = aw_hs;
    req_wstart = 1'b1; req_waddr = 12'h0C0; req_wdata = 32'h7777_0000; req_wstrb = 4'hF;
    tick();
    req_wstart = 1'b0;
    `CK("rst_awvalid_before", axi_awvalid, 1'b1);
    #2;
    axi_aresetn = 1'b0;
    #1;
    chk_zero("arst");
    tests++;
    if (axi_awvalid !== 1'b0) begin
      fails++;
      $error("FAIL arst_awvalid_direct: observed %b", axi_awvalid);
    end
    @(negedge axi_aclk);
    monitor();
    #1;
    axi_aresetn = 1'b1;
    @(posedge axi_aclk);
    #1;
    aw_dly = 0;
    repeat (5) tick();
    `CK("rst_awvalid_after", axi_awvalid, 1'b0);
    `CK("rst_wbusy_after", req_wbusy, 1'b0);
    `CK("rst_no_aw", aw_hs - awh0, 0);
    tests++;
    if (aw_hs !== awh0) begin
      fails++;
      $error("FAIL rst_no_aw_direct: %0d AW beats after reset", aw_hs - awh0);
    end

`ifdef AXI_BRESP_EN
    // Error response sets req_werr, next OKAY clears it
    aw_dly = 0; w_dly = 0; b_dly = 2; b_resp = 2'b10;
    req_wstart = 1'b1; req_waddr = 12'h040; req_wdata = 32'h0BAD_0BAD; req_wstrb = 4'hF;
    tick();
    req_wstart = 1'b0;
    wait_wdone("b1", 30);
    `CK("b1_werr", req_werr, 1'b1);
    b_resp = 2'b00;
    req_wstart = 1'b1; req_waddr = 12'h044; req_wdata = 32'h600D_600D;
    tick();
    req_wstart = 1'b0;
    `CK("b2_werr_held", req_werr, 1'b1);
    wait_wdone("b2", 30);
    `CK("b2_werr_clear", req_werr, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
